// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W-bit unsigned operands plus a carry-in, one 4-bit digit per
//   clock. The result is W = 4*NIBBLES bits plus a carry-out.
//   The operands are captured when start is accepted in IDLE or FIN.
//   The digits are then processed least-significant first in RUN.
//   sum/cout are updated only on the edge that finishes the last digit, so
//   partial results never reach the ports.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : begin an addition (sampled in IDLE/FIN only)
//   a, b   : W-bit operands, captured on the accepting edge
//   cin    : carry-in, captured on the accepting edge
//   busy   : high while in RUN
//   done   : one-cycle pulse (FIN) when sum/cout hold a new result
//   sum    : registered low W bits of a + b + cin
//   cout   : registered bit W of a + b + cin
module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  // The counter is wide enough to hold k+1 after the last digit.
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sum_w;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;

  // Digit datapath
  logic [CW+1:0]   sh;      // bit offset of digit k = 4*k
  logic [3:0]      nib_a, nib_b;
  logic [4:0]      nib_sum;
  logic [W-1:0]    sum_nxt; // working sum with digit k replaced
  logic            last;

  always_comb begin
    sh      = {cnt_q, 2'b00};
    nib_a   = 4'(a_q >> sh);
    nib_b   = 4'(b_q >> sh);
    nib_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
    sum_nxt = (sum_w & ~(W'(4'hF) << sh)) | (W'(nib_sum[3:0]) << sh);
    last    = (cnt_q == CW'(NIBBLES - 1));
  end

  // Next-state and decoded outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: state_d = start ? RUN : IDLE;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_w   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_w   <= sum_nxt;
          carry_q <= nib_sum[4];
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            sum  <= sum_nxt;
            cout <= nib_sum[4];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W:0]   exp_res = '0;   // expected {cout,sum}

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One addition; assumes the DUT is in IDLE or FIN. Operands are scrambled
  // during RUN to show they are not re-sampled. With hold_start set, start
  // stays high so the next call is accepted straight from FIN.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic oc, input bit hold_start);
    a = oa; b = ob; cin = oc; start = 1'b1;
    tick();                                   // E0: accept
    if (!hold_start) start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (k < N || 1) begin
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
        chk("hold_res", {cout, sum}, exp_res);
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();                                 // E_k
    end
    exp_res = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
    chk("done_pulse", done, 1);
    chk("busy_fin",   busy, 0);
    chk("result",     {cout, sum}, exp_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;

    // Directed cases
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("sum_5555", sum, 16'h5555);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold", {cout, sum}, exp_res);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("ripple", {cout, sum}, 17'h10000);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);   // accepted from FIN
    chk("all_ones", {cout, sum}, 17'h1FFFF);
    tick();

    // start held high: one result every N+1 cycles
    for (int j = 0; j < 4; j++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    start = 1'b0;
    tick();
    chk("b2b_idle", done, 0);

    // Reset in the middle of an operation (asserted for edge E2)
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    rst = 1'b1;
    tick();                                   // E2 with reset
    rst = 1'b0;
    exp_res = '0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res",  {cout, sum}, 0);
    for (int k = 0; k < N + 1; k++) begin
      tick();
      chk("abort_nodone", done, 0);
    end
    run_op(16'hABCD, 16'h1111, 1'b1, 1'b0);
    chk("post_abort", {cout, sum}, 17'h0BCDF);

    // Random operands, with random idle gaps
    for (int j = 0; j < 100; j++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_done", done, 0);
      end
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end

    if (n_fail == 0) $display("*Passed*");
    else             $display("*ERROR*");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001: Parameter NIBBLES, default 4, number of 4-bit digits per operand (operand width W = 4*NIBBLES); legal range 1..8.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: start  input  1  request to begin an addition; sampled only in IDLE or FIN.
REQ-005: a  input  W  first operand; captured on the accepting edge only.
REQ-006: b  input  W  second operand; captured on the accepting edge only.
REQ-007: cin  input  1  carry-in; captured on the accepting edge only.
REQ-008: busy  output  1  high while an addition is in progress (RUN).
REQ-009: done  output  1  single-cycle pulse marking a new valid result.
REQ-010: sum  output  W  registered result of a + b + cin, low W bits.
REQ-011: cout  output  1  registered carry-out, bit W of a + b + cin.

Function
REQ-012: The block SHALL be a 3-state FSM: IDLE, RUN and FIN, encoded in a state register.
REQ-013: IDLE/FIN with start=1 at an edge SHALL accept: latch a, b and cin into working registers, set nibble counter=0, go RUN.
REQ-014: IDLE/FIN with start=0 SHALL go (or stay) IDLE.
REQ-015: In RUN, each edge SHALL compute {c,s} = a_nib[k] + b_nib[k] + carry (5-bit result of a 4-bit add), store s in working-sum nibble k, set carry<=c and counter<=k+1.
REQ-016: The carry register SHALL hold cin before nibble 0 and the carry out of nibble k-1 before nibble k.
REQ-017: On the RUN edge that processes nibble NIBBLES-1, the block SHALL copy the working sum to sum and the final carry to cout, and go FIN.
REQ-018: Latency: with start accepted at edge E0, nibbles are processed at edges E1..E_N; done and the new sum/cout SHALL be visible after edge E_N (N = NIBBLES).
REQ-019: busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in FIN; they SHALL never be 1 together.
REQ-020: start SHALL be ignored in RUN; a, b and cin changes during RUN SHALL NOT affect the result.
REQ-021: start accepted in FIN SHALL begin a new operation with no idle cycle, so start held high gives one result every N+1 cycles.
REQ-022: sum and cout SHALL hold their last value from one done pulse until the next done pulse, including through RUN.
REQ-023: Working registers SHALL be invisible at the ports; no partial result SHALL appear on sum.
REQ-024: Arithmetic SHALL be unsigned; {cout,sum} SHALL equal a + b + cin exactly for all inputs, including the all-ones case.

Reset
REQ-025: rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, working registers=0.
REQ-026: rst SHALL take priority over start and over an in-progress operation; an aborted operation SHALL produce no done pulse and SHALL leave sum=0 and cout=0.
REQ-027: After rst deasserts, the first start SHALL be accepted at the next edge where start=1.

Verification (NIBBLES=4)
REQ-028: rst high 2 cycles -> busy=0, done=0, sum=16'h0000, cout=0.
REQ-029: a=16'h1234, b=16'h4321, cin=0 -> busy high 4 cycles, then done pulse for 1 cycle, sum=16'h5555, cout=0.
REQ-030: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry ripples across all nibbles); a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
REQ-031: start held high; a and b toggled during RUN -> extra starts ignored, results match the operands captured at each accept, done period = 5 cycles, sum stable between pulses.
REQ-032: rst asserted at E2 of an operation -> IDLE next cycle, no done pulse, sum=0, cout=0; next start computes correctly.
REQ-033: 100 random {a,b,cin} -> at each done, {cout,sum} == a+b+cin; print *Passed*, or *ERROR* on mismatch.
